// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, decode constants and issue beat type
package alu_pkg;
  localparam int ISSUE_XLEN   = 32;
  localparam int ISSUE_REG_AW = 5;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  typedef struct packed {
    logic [ISSUE_XLEN-1:0]   A;
    logic [ISSUE_XLEN-1:0]   B;
    alu_op_e                 ALU_control;
    logic [ISSUE_REG_AW-1:0] rd;
    logic                    illegal;
  } issue_beat_t;
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I decode of instr + register reads into an issue beat
//   instr, rs1_data, rs2_data in; beat out (A, B, ALU_control, rd, illegal)
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]           instr,
  input  logic [ISSUE_XLEN-1:0] rs1_data,
  input  logic [ISSUE_XLEN-1:0] rs2_data,
  output issue_beat_t           beat
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic f3_ok, r_legal, i_legal, legal, unused_rs1_idx;
  logic [ISSUE_XLEN-1:0] imm;
  alu_op_e op;
  assign opc            = instr[6:0];
  assign f3             = instr[14:12];
  assign f7             = instr[31:25];
  assign unused_rs1_idx = ^instr[19:15];
  assign f3_ok   = f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR;
  assign r_legal = opc == OPC_RTYPE && ((f7 == F7_BASE && f3_ok) || (f7 == F7_SUB && f3 == F3_ADD));
  assign i_legal = opc == OPC_ITYPE && f3_ok;
  assign legal   = r_legal || i_legal;
  assign imm     = {{(ISSUE_XLEN-12){instr[31]}}, instr[31:20]};
  // SUB is only reachable through the R-type funct7 check; the rest follow funct3
  assign op = (opc == OPC_RTYPE && f7 == F7_SUB) ? ALU_SUB :
              f3 == F3_AND ? ALU_AND :
              f3 == F3_OR  ? ALU_OR  : ALU_ADD;
  always_comb begin
    beat.A           = legal ? rs1_data : '0;
    beat.B           = !legal ? '0 : r_legal ? rs2_data : imm;
    beat.ALU_control = legal ? op : ALU_ADD;
    beat.rd          = legal ? instr[11:7] : '0;
    beat.illegal     = !legal;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage feeding the ALU through a 2-entry skid buffer
//   in_valid/in_ready + instr/rs1_data/rs2_data upstream; out_valid/out_ready + A/B/ALU_control/rd/illegal downstream
//   ALU_ISSUE_PERF_EN adds perf_issued/perf_stall counters
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = ISSUE_XLEN,
  parameter int REG_AW = ISSUE_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic [1:0]        ALU_control,
  output logic [REG_AW-1:0] rd,
`ifdef ALU_ISSUE_PERF_EN
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall,
`endif
  output logic              illegal
);
  issue_beat_t dec, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_fire, main_free;
  alu_issue_decode u_dec (.instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .beat(dec));
  assign in_fire   = in_valid && in_ready_q;
  assign main_free = !main_v_q || out_ready;
  // in_ready_q mirrors !skid_v_q, so the skid is never written while occupied
  always_comb begin
    main_v_d = main_free ? (skid_v_q || in_fire) : main_v_q;
    main_d   = !main_free ? main_q : skid_v_q ? skid_q : in_fire ? dec : main_q;
    skid_v_d = main_free ? 1'b0 : (skid_v_q || in_fire);
    skid_d   = (!main_free && in_fire) ? dec : skid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= !skid_v_d;
    end
  end
  assign in_ready    = in_ready_q;
  assign out_valid   = main_v_q;
  assign A           = main_q.A;
  assign B           = main_q.B;
  assign ALU_control = main_q.ALU_control;
  assign rd          = main_q.rd;
  assign illegal     = main_q.illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issued_q, stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_q + {31'd0, main_v_q && out_ready};
      stall_q  <= stall_q + {31'd0, main_v_q && !out_ready};
    end
  end
  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif
endmodule
